// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: funct bit positions per op class and FSM states.
package alu_pkg;

    // Register class
    localparam int F_ADD  = 0;
    localparam int F_SUB  = 1;
    localparam int F_FABS = 2;
    localparam int F_FNEG = 3;
    localparam int F_MUL  = 4;
    // Immediate class (F_ADD/F_SUB are reused as addi/subi)
    localparam int F_SLLI = 2;
    // Mov class
    localparam int F_MOVL = 0;
    localparam int F_MOVH = 1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: start loads operands, one partial product per clock,
// done/p are presented combinationally on the final iteration so the caller can capture p.
module alu_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] p
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = running && (cnt == CNT_W'(XLEN - 1));
    assign p        = acc_next;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Operand/accumulator datapath carries no reset; running gates its use.
    always_ff @(posedge clk) begin
        if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with a registered valid/ready result. Defining ALU_MUL_EN adds
// the multi-cycle shift-add multiplier on reg-class funct[4] and drives busy while it iterates.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 8,
    parameter int FUNCT_W = 5
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               en,
    input  logic               imm,
    input  logic               mov,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [IMM_W-1:0]   src1,
    input  logic [IMM_W-1:0]   src2,
    input  logic [XLEN-1:0]    read1,
    input  logic [XLEN-1:0]    read2,
    input  logic [XLEN-1:0]    read_dest,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               busy
);
    alu_state_e      state;
    logic            accept;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] shl;
    logic [XLEN-1:0] res_comb;
    logic            unused_bits;

    assign accept   = in_valid & in_ready;
    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign ext      = XLEN'(src2);
    assign shl      = (ext >= XLEN'(XLEN)) ? '0 : (read1 << ext);

    assign unused_bits = ^{read_dest[XLEN-1:XLEN-2*IMM_W], funct[FUNCT_W-1:F_MUL]};

    // Class mux: every selected funct bit within the class ORs its result in.
    always_comb begin
        res_comb = '0;
        if (en) begin
            if (!imm) begin
                if (funct[F_ADD])  res_comb = res_comb | (read1 + read2);
                if (funct[F_SUB])  res_comb = res_comb | (read1 - read2);
                if (funct[F_FABS]) res_comb = res_comb | {1'b0, read2[XLEN-2:0]};
                if (funct[F_FNEG]) res_comb = res_comb | {~read2[XLEN-1], read2[XLEN-2:0]};
            end else if (mov) begin
                if (funct[F_MOVL]) res_comb = res_comb | XLEN'({src1, src2});
                if (funct[F_MOVH]) res_comb = res_comb | {src1, src2, read_dest[XLEN-2*IMM_W-1:0]};
            end else begin
                if (funct[F_ADD])  res_comb = res_comb | (read1 + ext);
                if (funct[F_SUB])  res_comb = res_comb | (read1 - ext);
                if (funct[F_SLLI]) res_comb = res_comb | shl;
            end
        end
    end

`ifdef ALU_MUL_EN
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_p;

    assign mul_start = accept & ~imm & en & funct[F_MUL];
    assign busy      = (state == MUL);

    alu_mul_seq #(
        .XLEN (XLEN)
    ) u_mul (
        .clk   (clk),
        .nrst  (nrst),
        .start (mul_start),
        .a     (read1),
        .b     (read2),
        .done  (mul_done),
        .p     (mul_p)
    );
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
`ifdef ALU_MUL_EN
            if (mul_start) begin
                state     <= MUL;
                out_valid <= 1'b0;
            end else if ((state == MUL) && mul_done) begin
                state     <= IDLE;
                out_valid <= 1'b1;
                result    <= mul_p;
            end else
`endif
            if (accept) begin
                out_valid <= 1'b1;
                result    <= res_comb;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops push expected results, a negedge monitor pops
// and compares on every out_valid & out_ready. Multiplier cases run when ALU_MUL_EN is defined.
`timescale 1ns/1ps
module tb_alu_pipe;
    logic        clk       = 1'b0;
    logic        nrst      = 1'b0;
    logic        in_valid  = 1'b0;
    logic        en        = 1'b0;
    logic        imm       = 1'b0;
    logic        mov       = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  funct     = '0;
    logic [7:0]  src1      = '0;
    logic [7:0]  src2      = '0;
    logic [31:0] read1     = '0;
    logic [31:0] read2     = '0;
    logic [31:0] read_dest = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_pipe dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .imm       (imm),
        .mov       (mov),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .read1     (read1),
        .read2     (read2),
        .read_dest (read_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %h expected no output", result);
            end else begin
                check("scoreboard", result, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input string name, input logic i_en, input logic i_imm, input logic i_mov,
                         input logic [4:0] f, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] rd,
                         input logic [31:0] expv, input bit push, input bit one_clk);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_in_ready_timeout: got in_ready=0 expected 1 within 100 clks", name);
            return;
        end
        en = i_en; imm = i_imm; mov = i_mov; funct = f;
        src1 = s1; src2 = s2; read1 = r1; read2 = r2; read_dest = rd;
        in_valid = 1'b1;
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (one_clk) check({name, "_lat1"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int busy_n;
        int seen;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Register class
        issue("add",      1, 0, 0, 5'b00001, 0, 0, 32'd5,          32'd7,          0, 32'd12,         1, 1);
        issue("add_wrap", 1, 0, 0, 5'b00001, 0, 0, 32'hFFFF_FFFF,  32'd2,          0, 32'd1,          1, 1);
        issue("sub",      1, 0, 0, 5'b00010, 0, 0, 32'd5,          32'd7,          0, 32'hFFFF_FFFE,  1, 1);
        issue("fabs",     1, 0, 0, 5'b00100, 0, 0, 32'd0,          32'h8000_0005,  0, 32'd5,          1, 1);
        issue("fneg_pos", 1, 0, 0, 5'b01000, 0, 0, 32'd0,          32'd5,          0, 32'h8000_0005,  1, 1);
        issue("fneg_neg", 1, 0, 0, 5'b01000, 0, 0, 32'd0,          32'h8000_0001,  0, 32'd1,          1, 1);
        issue("add_or_sub", 1, 0, 0, 5'b00011, 0, 0, 32'd5,        32'd3,          0, 32'd10,         1, 1);
        issue("funct_zero", 1, 0, 0, 5'b00000, 0, 0, 32'd5,        32'd7,          0, 32'd0,          1, 1);
        issue("en_off",   0, 0, 0, 5'b00001, 0, 0, 32'd5,          32'd7,          0, 32'd0,          1, 1);

        // Immediate class
        issue("addi",     1, 1, 0, 5'b00001, 0, 8'd200, 32'd100,   0,              0, 32'd300,        1, 1);
        issue("subi",     1, 1, 0, 5'b00010, 0, 8'd1,   32'd0,     0,              0, 32'hFFFF_FFFF,  1, 1);
        issue("slli31",   1, 1, 0, 5'b00100, 0, 8'd31,  32'd1,     0,              0, 32'h8000_0000,  1, 1);
        issue("slli32",   1, 1, 0, 5'b00100, 0, 8'd32,  32'd1,     0,              0, 32'd0,          1, 1);
        issue("imm_f4",   1, 1, 0, 5'b10000, 0, 8'd4,   32'd9,     0,              0, 32'd0,          1, 1);

        // Mov class
        issue("movl",     1, 1, 1, 5'b00001, 8'hAB, 8'hCD, 0, 0, 32'h1234, 32'h0000_ABCD, 1, 1);
        issue("movh",     1, 1, 1, 5'b00010, 8'hAB, 8'hCD, 0, 0, 32'h1234, 32'hABCD_1234, 1, 1);
        issue("movl_movh", 1, 1, 1, 5'b00011, 8'hAB, 8'hCD, 0, 0, 32'h1234, 32'hABCD_BBFD, 1, 1);

        // Output backpressure holds the result and blocks new ops
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue("stall_add", 1, 0, 0, 5'b00001, 0, 0, 32'd5, 32'd7, 0, 32'd12, 1, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_result", result, 32'd12);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_drained", {31'b0, out_valid}, 32'd0);

`ifdef ALU_MUL_EN
        issue("mul", 1, 0, 0, 5'b10000, 0, 0, 32'hFFFF_FFFF, 32'd3, 0, 32'hFFFF_FFFD, 1, 0);
        lat = 0;
        busy_n = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("mul_latency", 32'(lat), 32'd32);
        check("mul_busy_clks", 32'(busy_n), 32'd32);
        check("mul_busy_done", {31'b0, busy}, 32'd0);
        issue("mul_override", 1, 0, 0, 5'b10001, 0, 0, 32'd6, 32'd7, 0, 32'd42, 1, 0);
        issue("mul_en_off",   0, 0, 0, 5'b10000, 0, 0, 32'd6, 32'd7, 0, 32'd0,  1, 1);

        // Reset in the middle of a multiply must drop it
        issue("mul_abort", 1, 0, 0, 5'b10000, 0, 0, 32'd6, 32'd7, 0, 32'd0, 0, 0);
        repeat (10) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        issue("after_abort", 1, 0, 0, 5'b00001, 0, 0, 32'd20, 32'd22, 0, 32'd42, 1, 1);
`else
        issue("nomul_f10001", 1, 0, 0, 5'b10001, 0, 0, 32'd2, 32'd3, 0, 32'd5, 1, 1);
        check("nomul_busy", {31'b0, busy}, 32'd0);
        issue("nomul_f10000", 1, 0, 0, 5'b10000, 0, 0, 32'd2, 32'd3, 0, 32'd0, 1, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
